// File: rtl/poly_note_synth.sv
// poly_note_synth: polyphonic square-wave synthesiser with voice allocation, saturating mixer and
// valid/ready sample port. Define ENVELOPE_EN for per-voice attack/release gain ramps.
module poly_note_synth #(
   parameter int NUM_NOTES  = 30,
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 32,
   parameter int AMPLITUDE  = 10000000,
   parameter int ENV_STEP   = 4096
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic [NUM_NOTES-1:0]       note_in,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid,
   input  logic                       sample_ready,
   output logic [NUM_VOICES-1:0]      voice_active,
   output logic                       voice_overflow
);

   localparam int IDX_W  = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam int SLOT_W = $clog2(NUM_VOICES + 1);
   localparam int HP_W   = 18;
   localparam int ACC_W  = SAMPLE_W + 3;

   localparam logic signed [ACC_W-1:0] AMP_ACC = ACC_W'(AMPLITUDE);
   localparam logic signed [ACC_W-1:0] SAT_POS = {4'b0000, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_NEG = -SAT_POS;

   // Half-period in clocks of each semitone in the lowest octave (C3..B3).
   function automatic logic [HP_W-1:0] base_half_period(input logic [3:0] semi);
      case (semi)
         4'd0:    return 18'd191113;
         4'd1:    return 18'd180388;
         4'd2:    return 18'd170262;
         4'd3:    return 18'd160705;
         4'd4:    return 18'd151685;
         4'd5:    return 18'd143172;
         4'd6:    return 18'd135139;
         4'd7:    return 18'd127551;
         4'd8:    return 18'd120395;
         4'd9:    return 18'd113636;
         4'd10:   return 18'd107259;
         default: return 18'd101239;
      endcase
   endfunction

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;

   state_t               state_reg;
   logic [NUM_NOTES-1:0] note_latch_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic [3:0]           semi_reg;
   logic [1:0]           oct_reg;
   logic [SLOT_W-1:0]    slot_cnt_reg;
   logic                 overflow_pending_reg;
   logic                 voice_overflow_reg;

   logic                 note_changed;
   logic                 relatch;
   logic                 commit;
   logic                 slot_free;
   logic                 scan_take;
   logic [HP_W-1:0]      scan_hp;

   assign note_changed = (note_in != note_latch_reg);
   assign relatch      = note_changed && (state_reg != ST_COMMIT);
   assign commit       = (state_reg == ST_COMMIT);
   assign slot_free    = (slot_cnt_reg < SLOT_W'(NUM_VOICES));
   assign scan_take    = (state_reg == ST_SCAN) && !note_changed && note_latch_reg[idx_reg] && slot_free;
   assign scan_hp      = base_half_period(semi_reg) >> oct_reg;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_reg            <= ST_IDLE;
         note_latch_reg       <= '0;
         idx_reg              <= '0;
         semi_reg             <= '0;
         oct_reg              <= '0;
         slot_cnt_reg         <= '0;
         overflow_pending_reg <= 1'b0;
         voice_overflow_reg   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE, ST_SCAN: begin
               if (note_changed) begin
                  // A change at any point (re)starts the scan from note 0.
                  state_reg            <= ST_SCAN;
                  note_latch_reg       <= note_in;
                  idx_reg              <= '0;
                  semi_reg             <= '0;
                  oct_reg              <= '0;
                  slot_cnt_reg         <= '0;
                  overflow_pending_reg <= 1'b0;
               end else if (state_reg == ST_SCAN) begin
                  if (note_latch_reg[idx_reg]) begin
                     if (slot_free)
                        slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
                     else
                        overflow_pending_reg <= 1'b1;
                  end
                  if (idx_reg == IDX_W'(NUM_NOTES - 1)) begin
                     state_reg <= ST_COMMIT;
                  end else begin
                     idx_reg <= idx_reg + IDX_W'(1);
                     if (semi_reg == 4'd11) begin
                        semi_reg <= '0;
                        oct_reg  <= oct_reg + 2'd1;
                     end else begin
                        semi_reg <= semi_reg + 4'd1;
                     end
                  end
               end
            end
            ST_COMMIT: begin
               voice_overflow_reg <= overflow_pending_reg;
               state_reg          <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef ENVELOPE_EN
   localparam int ENV_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;
   logic [ENV_W-1:0] env_cnt_reg;
   logic             env_tick;

   assign env_tick = (env_cnt_reg == ENV_W'(ENV_STEP - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset || env_tick)
         env_cnt_reg <= '0;
      else
         env_cnt_reg <= env_cnt_reg + ENV_W'(1);
   end
`endif

   logic signed [ACC_W-1:0] contrib [NUM_VOICES];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         logic              slot_used_reg;
         logic [IDX_W-1:0]  slot_note_reg;
         logic [HP_W-1:0]   slot_hp_reg;
         logic [HP_W-1:0]   cnt_reg;
         logic [HP_W-1:0]   hp_reg;
         logic [IDX_W-1:0]  note_reg;
         logic              phase_reg;
         logic              act_reg;
         logic              wrap;
         logic              same_note;

         assign wrap = (cnt_reg == hp_reg - HP_W'(1));

         // Slot gi receives the gi-th set note found during the scan.
         always_ff @(posedge CLOCK_50) begin
            if (reset || relatch) begin
               slot_used_reg <= 1'b0;
               slot_note_reg <= '0;
               slot_hp_reg   <= '0;
            end else if (scan_take && (slot_cnt_reg == SLOT_W'(gi))) begin
               slot_used_reg <= 1'b1;
               slot_note_reg <= idx_reg;
               slot_hp_reg   <= scan_hp;
            end
         end

`ifdef ENVELOPE_EN
         logic       held_reg;
         logic [8:0] gain_reg;
         logic signed [ACC_W+9:0] amp_s;
         logic signed [ACC_W+9:0] scaled;

         assign same_note = held_reg && (note_reg == slot_note_reg);

         always_ff @(posedge CLOCK_50) begin
            if (reset) begin
               cnt_reg   <= '0;
               hp_reg    <= '0;
               note_reg  <= '0;
               phase_reg <= 1'b0;
               act_reg   <= 1'b0;
               held_reg  <= 1'b0;
               gain_reg  <= '0;
            end else if (commit && slot_used_reg && !same_note) begin
               cnt_reg   <= '0;
               hp_reg    <= slot_hp_reg;
               note_reg  <= slot_note_reg;
               phase_reg <= 1'b1;
               act_reg   <= 1'b1;
               held_reg  <= 1'b1;
               gain_reg  <= '0;
            end else begin
               if (act_reg) begin
                  cnt_reg <= wrap ? '0 : cnt_reg + HP_W'(1);
                  if (wrap)
                     phase_reg <= ~phase_reg;
               end
               if (commit && !slot_used_reg)
                  held_reg <= 1'b0;
               // Released voices keep toggling while their gain ramps down to silence.
               if (!held_reg && act_reg) begin
                  if (gain_reg == '0) begin
                     act_reg   <= 1'b0;
                     cnt_reg   <= '0;
                     phase_reg <= 1'b0;
                  end else if (env_tick) begin
                     gain_reg <= gain_reg - 9'd1;
                  end
               end else if (held_reg && env_tick && (gain_reg != 9'd256)) begin
                  gain_reg <= gain_reg + 9'd1;
               end
            end
         end

         assign amp_s  = phase_reg ? (ACC_W+10)'(AMP_ACC) : -(ACC_W+10)'(AMP_ACC);
         assign scaled = amp_s * (ACC_W+10)'($signed({1'b0, gain_reg}));
         assign contrib[gi] = act_reg ? ACC_W'(scaled >>> 8) : '0;
`else
         assign same_note = act_reg && (note_reg == slot_note_reg);

         // An unchanged note keeps counting through commit so its waveform stays continuous.
         always_ff @(posedge CLOCK_50) begin
            if (reset) begin
               cnt_reg   <= '0;
               hp_reg    <= '0;
               note_reg  <= '0;
               phase_reg <= 1'b0;
               act_reg   <= 1'b0;
            end else if (commit && slot_used_reg && !same_note) begin
               cnt_reg   <= '0;
               hp_reg    <= slot_hp_reg;
               note_reg  <= slot_note_reg;
               phase_reg <= 1'b1;
               act_reg   <= 1'b1;
            end else if (commit && !slot_used_reg) begin
               cnt_reg   <= '0;
               phase_reg <= 1'b0;
               act_reg   <= 1'b0;
            end else if (act_reg) begin
               cnt_reg <= wrap ? '0 : cnt_reg + HP_W'(1);
               if (wrap)
                  phase_reg <= ~phase_reg;
            end
         end

         assign contrib[gi] = act_reg ? (phase_reg ? AMP_ACC : -AMP_ACC) : '0;
`endif

         assign voice_active[gi] = act_reg;
      end
   endgenerate

   logic signed [ACC_W-1:0]    mix_sum;
   logic signed [SAMPLE_W-1:0] mix_next;
   logic signed [SAMPLE_W-1:0] mix_reg;
   logic signed [SAMPLE_W-1:0] sample_out_reg;
   logic                       sample_valid_reg;

   always_comb begin
      mix_sum = '0;
      for (int v = 0; v < NUM_VOICES; v++)
         mix_sum = mix_sum + contrib[v];
      if (mix_sum > SAT_POS)
         mix_next = SAT_POS[SAMPLE_W-1:0];
      else if (mix_sum < SAT_NEG)
         mix_next = SAT_NEG[SAMPLE_W-1:0];
      else
         mix_next = mix_sum[SAMPLE_W-1:0];
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         mix_reg          <= '0;
         sample_out_reg   <= '0;
         sample_valid_reg <= 1'b0;
      end else begin
         mix_reg          <= mix_next;
         sample_valid_reg <= 1'b1;
         if (!sample_valid_reg || sample_ready)
            sample_out_reg <= mix_reg;
      end
   end

   assign sample_out     = sample_out_reg;
   assign sample_valid   = sample_valid_reg;
   assign voice_overflow = voice_overflow_reg;

endmodule

// File: tb/tb_poly_note_synth.sv
// Scoreboard bench for poly_note_synth: stimulus queues cycle-tagged expectations, a monitor checks them.
module tb_poly_note_synth;

   localparam int NN = 48;
   localparam int NV = 4;
   localparam int SW = 32;
   localparam int A  = 10000000;

   logic                 CLOCK_50 = 1'b0;
   logic                 reset = 1'b1;
   logic [NN-1:0]        note_in = '0;
   logic signed [SW-1:0] sample_out;
   logic                 sample_valid;
   logic                 sample_ready = 1'b1;
   logic [NV-1:0]        voice_active;
   logic                 voice_overflow;

   always #5 CLOCK_50 = ~CLOCK_50;

   poly_note_synth #(
      .NUM_NOTES(NN), .NUM_VOICES(NV), .SAMPLE_W(SW), .AMPLITUDE(A), .ENV_STEP(4096)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .note_in(note_in),
      .sample_out(sample_out),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .voice_active(voice_active),
      .voice_overflow(voice_overflow)
   );

   typedef struct {
      int            due;
      string         name;
      bit            chk_s;
      int            sample;
      bit            valid;
      logic [NV-1:0] va;
      bit            ov;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   function automatic logic [NN-1:0] nb(input int i);
      logic [NN-1:0] r;
      r = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic push_exp(input int due, input string name, input bit chk_s, input int s,
                           input bit v, input logic [NV-1:0] va, input bit ov);
      exp_t e;
      e.due = due; e.name = name; e.chk_s = chk_s; e.sample = s; e.valid = v; e.va = va; e.ov = ov;
      exp_q.push_back(e);
   endtask

   // Returns just after the posedge that brings cyc to target.
   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   // Monitor: compares outputs on the negedge of each expectation's due cycle.
   initial begin
      forever begin
         @(negedge CLOCK_50);
         while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (e.due < cyc) begin
               n_miss++;
               $display("FAIL %s: not checked at due cycle %0d (now %0d)", e.name, e.due, cyc);
            end else if (sample_valid !== e.valid || voice_active !== e.va || voice_overflow !== e.ov ||
                         (e.chk_s && sample_out !== e.sample)) begin
               n_miss++;
               $display("FAIL %s @%0d: got sample=%0d valid=%b active=%b ovf=%b, want sample=%s valid=%b active=%b ovf=%b",
                        e.name, cyc, sample_out, sample_valid, voice_active, voice_overflow,
                        e.chk_s ? $sformatf("%0d", e.sample) : "any", e.valid, e.va, e.ov);
            end else begin
               $display("ok   %s @%0d: sample=%0d valid=%b active=%b ovf=%b",
                        e.name, cyc, sample_out, sample_valid, voice_active, voice_overflow);
            end
         end
      end
   end

   initial begin
      int p, c3, c4, c5, p6, pl, p7, r, c8;

      // T1: reset held three cycles
      push_exp(3, "reset_state", 1, 0, 0, 4'b0000, 0);
      push_exp(4, "valid_after_reset", 1, 0, 1, 4'b0000, 0);
      wait_cyc(3);
      reset = 1'b0;

      // T2: single note 47 (B6), half-period 12654
      wait_cyc(5);
      p = cyc;
      note_in = nb(47);
      push_exp(p + 49, "single_before_commit", 0, 0, 1, 4'b0000, 0);
      push_exp(p + 50, "single_commit", 1, 0, 1, 4'b0001, 0);
      push_exp(p + 52, "single_first_sample", 1, A, 1, 4'b0001, 0);
      push_exp(p + 51 + 12654, "single_last_high", 1, A, 1, 4'b0001, 0);
      push_exp(p + 52 + 12654, "single_first_low", 1, -A, 1, 4'b0001, 0);

      // T3: chord 36/40/43 (hp 23889/18960/15943), with T5 back-pressure window inside
      wait_cyc(p + 52 + 12654);
      c3 = cyc + 50;
      note_in = nb(36) | nb(40) | nb(43);
      push_exp(c3 - 1, "chord_before_commit", 0, 0, 1, 4'b0001, 0);
      push_exp(c3, "chord_commit", 0, 0, 1, 4'b0111, 0);
      push_exp(c3 + 2, "chord_all_high", 1, 3 * A, 1, 4'b0111, 0);
      push_exp(c3 + 15944, "chord_v2_last_high", 1, 3 * A, 1, 4'b0111, 0);
      push_exp(c3 + 15945, "chord_v2_low", 1, A, 1, 4'b0111, 0);
      push_exp(c3 + 19000, "hold_mid", 1, A, 1, 4'b0111, 0);
      push_exp(c3 + 19050, "hold_end", 1, A, 1, 4'b0111, 0);
      push_exp(c3 + 19051, "hold_release", 1, -A, 1, 4'b0111, 0);
      push_exp(c3 + 23890, "chord_v0_last_high", 1, -A, 1, 4'b0111, 0);
      push_exp(c3 + 23891, "chord_all_low", 1, -3 * A, 1, 4'b0111, 0);
      wait_cyc(c3 + 18950);
      sample_ready = 1'b0;
      wait_cyc(c3 + 19050);
      sample_ready = 1'b1;

      // T4: six notes into four voices; voice 0 keeps note 36 without restarting
      wait_cyc(c3 + 23891);
      c4 = cyc + 50;
      note_in = nb(36) | nb(37) | nb(38) | nb(39) | nb(40) | nb(41);
      push_exp(c4 - 1, "ovf_before_commit", 0, 0, 1, 4'b0111, 0);
      push_exp(c4, "ovf_commit", 0, 0, 1, 4'b1111, 1);
      push_exp(c4 + 2, "ovf_kept_phase", 1, 2 * A, 1, 4'b1111, 1);

      wait_cyc(c4 + 2);
      c5 = cyc + 50;
      note_in = nb(36) | nb(37) | nb(38) | nb(39);
      push_exp(c5 - 1, "four_before_commit", 0, 0, 1, 4'b1111, 1);
      push_exp(c5, "four_commit_no_ovf", 0, 0, 1, 4'b1111, 0);
      push_exp(c5 + 2, "four_all_kept", 1, 2 * A, 1, 4'b1111, 0);

      // T6: note changed at scan cycle 10 restarts the scan
      wait_cyc(c5 + 2);
      p6 = cyc;
      note_in = nb(44);
      push_exp(p6 + 50, "restart_no_commit", 0, 0, 1, 4'b1111, 0);
      wait_cyc(p6 + 10);
      pl = cyc;
      note_in = nb(45);
      push_exp(pl + 49, "restart_before_commit", 0, 0, 1, 4'b1111, 0);
      push_exp(pl + 50, "restart_commit", 0, 0, 1, 4'b0001, 0);
      push_exp(pl + 52, "restart_first", 1, A, 1, 4'b0001, 0);
      push_exp(pl + 51 + 14204, "restart_last_high", 1, A, 1, 4'b0001, 0);
      push_exp(pl + 52 + 14204, "restart_first_low", 1, -A, 1, 4'b0001, 0);

      // Reset in the middle of a scan
      wait_cyc(pl + 52 + 14204);
      p7 = cyc;
      note_in = nb(47);
      push_exp(p7 + 20, "midscan_reset", 1, 0, 0, 4'b0000, 0);
      push_exp(p7 + 21, "midscan_reset_hold", 1, 0, 0, 4'b0000, 0);
      wait_cyc(p7 + 19);
      reset = 1'b1;
      wait_cyc(p7 + 21);
      reset = 1'b0;
      r = cyc;
      push_exp(r + 49, "rescan_before_commit", 0, 0, 1, 4'b0000, 0);
      push_exp(r + 50, "rescan_commit", 0, 0, 1, 4'b0001, 0);
      push_exp(r + 52, "rescan_first", 1, A, 1, 4'b0001, 0);

      // All notes released
      wait_cyc(r + 52);
      c8 = cyc + 50;
      note_in = '0;
      push_exp(c8 - 1, "silence_before_commit", 0, 0, 1, 4'b0001, 0);
      push_exp(c8, "silence_commit", 0, 0, 1, 4'b0000, 0);
      push_exp(c8 + 2, "silence_sample", 1, 0, 1, 4'b0000, 0);

      wait_cyc(c8 + 4);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLOCK_50);
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         n_miss++;
         $display("FAIL %s: never checked (due %0d, now %0d)", e.name, e.due, cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
